// File: rtl/rowbias_pkg.sv
// Shared definitions for the row-bias reshuffle controller: FSM state
// encoding, LFSR feedback taps and the per-row settle-time helper.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package rowbias_pkg;

    // Sequencer states; exported on the debug port of rowbias_ctrl.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } rowbias_state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A row needs two random draws per pool slot plus one cycle to
    // latch its result before the pool is considered valid.
    function automatic int settle_cycles(input int width);
        return 2 * width + 1;
    endfunction

    // One step of the Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/rowbias_lfsr.sv
// 16-bit Galois LFSR with synchronous reset to SEED, an advance enable
// and a load port used for reseeding. Load takes priority over advance.
module rowbias_lfsr
    import rowbias_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: load, step, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_value;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/rowbias_ctrl.sv
// Row-bias reshuffle sequencer. On start it resets each row in turn with a
// one-cycle pulse, waits SETTLE cycles for that row to shuffle its pool
// from the shared random bus, then marks the row ready.
// Optional feature: define ROWBIAS_CTRL_RESEED_EN to mix a free-running
// cycle counter into the LFSR at every accepted start.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

module rowbias_ctrl
    import rowbias_pkg::*;
#(
    parameter int          NUM_ROWS   = `GRID_LEN,
    parameter int          WIDTH      = `GRID_LEN,
    parameter int          RAND_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_ROWS-1:0]   row_reset,
    output logic [RAND_WIDTH-1:0] random,
    output logic [NUM_ROWS-1:0]   row_ready,
    output rowbias_state_e        dbg_state
);

    localparam int SETTLE = settle_cycles(WIDTH);
    localparam int SCW    = $clog2(SETTLE + 1);
    localparam int RIW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    if (RAND_WIDTH < 1 || RAND_WIDTH > 16 || LFSR_SEED == 16'h0000) begin : g_param_err
        $error("rowbias_ctrl: RAND_WIDTH must be 1..16 and LFSR_SEED nonzero");
    end

    rowbias_state_e        state_q, state_d;
    logic [RIW-1:0]        row_q, row_d;
    logic [SCW-1:0]        settle_q, settle_d;
    logic [NUM_ROWS-1:0]   ready_q, ready_d;
    logic [NUM_ROWS-1:0]   row_mask;
    logic                  last_wait;
    logic                  accept;
    logic                  lfsr_load;
    logic [15:0]           lfsr_load_value;
    logic [15:0]           lfsr_state;

    assign row_mask  = NUM_ROWS'(1) << row_q;
    assign last_wait = (state_q == ST_WAIT) && (settle_q == SCW'(SETTLE - 1));
    assign accept    = (state_q == ST_IDLE) && start;

    // State and sequencing registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            settle_q <= '0;
            ready_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state: walk rows PULSE -> WAIT x SETTLE, then DONE.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        ready_d  = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ready_d = '0;
                    row_d   = '0;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                settle_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (last_wait) begin
                    ready_d = ready_q | row_mask;
                    if (row_q == RIW'(NUM_ROWS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + RIW'(1);
                        state_d = ST_PULSE;
                    end
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: the finishing row shows ready during its last settle cycle.
    always_comb begin
        busy      = (state_q == ST_PULSE) || (state_q == ST_WAIT);
        done      = (state_q == ST_DONE);
        row_reset = (state_q == ST_PULSE) ? row_mask : '0;
        row_ready = ready_q | (last_wait ? row_mask : '0);
        random    = lfsr_state[RAND_WIDTH-1:0];
        dbg_state = state_q;
    end

`ifdef ROWBIAS_CTRL_RESEED_EN
    logic [15:0] counter_q, counter_d;
    logic [15:0] mixed;

    // Free-running cycle counter used as reseed entropy.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    // Reseed value; a zero result would lock the LFSR, so fall back to seed.
    always_comb begin
        counter_d       = counter_q + 16'd1;
        mixed           = lfsr_state ^ counter_q;
        lfsr_load       = accept;
        lfsr_load_value = (mixed == 16'h0000) ? LFSR_SEED : mixed;
    end
`else
    // No reseeding: every run after reset replays the same random stream.
    always_comb begin
        lfsr_load       = 1'b0;
        lfsr_load_value = lfsr_state;
    end
`endif

    rowbias_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .advance   (busy),
        .load      (lfsr_load),
        .load_value(lfsr_load_value),
        .state     (lfsr_state)
    );

endmodule
